// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO: Gray/binary conversion and pointer width.
// Latency: pure functions, no state.
// Backpressure: not applicable.
package fifo_pkg;

    // Widest pointer the helpers handle.
    localparam int GRAY_MAX_W = 32;

    // Pointers carry one extra wrap bit above the memory address.
    function automatic int ptr_width(input int addr_size);
        return addr_size + 1;
    endfunction

    // Both conversions work on a zero-extended GRAY_MAX_W word. Leading zeros
    // map to leading zeros in either direction, so callers of any width up to
    // GRAY_MAX_W cast in and truncate out.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down, done in log2 doubling steps.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int s = 1; s < GRAY_MAX_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Binary to Gray code converter, WIDTH bits (WIDTH <= 32).
// Latency: combinational.
// Backpressure: none.
// Ports: i_bin binary input, o_gray Gray output.
module binary_to_gray
    import fifo_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    assign o_gray = WIDTH'(bin2gray(GRAY_MAX_W'(i_bin)));

endmodule

// File: rtl/gray_to_binary.sv
// Gray to binary code converter, WIDTH bits (WIDTH <= 32).
// Latency: combinational.
// Backpressure: none.
// Ports: i_gray Gray input, o_bin binary output.
module gray_to_binary
    import fifo_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    assign o_bin = WIDTH'(gray2bin(GRAY_MAX_W'(i_gray)));

endmodule

// File: rtl/rd_ptr_level.sv
// Read-domain pointer/status controller for the async FIFO: read pointers, empty, fill level, almost-empty, underflow.
// Latency: a pop or a synchronised write-pointer change in cycle N shows in every registered output at edge N+1.
// Backpressure: rd_fire = rd_en & ~empty; a pop while empty is dropped (and flagged when underflow is compiled in).
//
// Ports:
//   rd_clk, rd_rst    read clock, asynchronous active-high reset
//   rd_en             pop request
//   rq2_wptr          Gray write pointer, already synchronised into rd_clk
//   uf_clr            clears the sticky underflow flag
//   rd_fire           accepted pop / memory read enable (combinational)
//   rd_ptr            memory read address
//   rd_ptr_gray       registered Gray read pointer, to the write domain
//   empty             registered empty flag
//   almost_empty      registered, level <= AE_THRESH
//   rd_level          registered unread-entry count, 0 .. 2^ADDR_SIZE
//   underflow         sticky rejected-pop flag
// Build option: define RD_UNDERFLOW_EN to compile in the underflow register;
// otherwise underflow is tied low and uf_clr is ignored.
module rd_ptr_level
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE:0]   rq2_wptr,
    input  logic                 uf_clr,
    output logic                 rd_fire,
    output logic [ADDR_SIZE-1:0] rd_ptr,
    output logic [ADDR_SIZE:0]   rd_ptr_gray,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   rd_level,
    output logic                 underflow
);

    localparam int PW = ptr_width(ADDR_SIZE);

    logic [PW-1:0] r_rbin;
    logic [PW-1:0] r_rgray;
    logic          r_empty;
    logic          r_almost_empty;
    logic [PW-1:0] r_level;

    logic          w_rd_fire;
    logic [PW-1:0] w_rbin_next;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_wbin_s;
    logic [PW-1:0] w_level_next;

    assign w_rd_fire   = rd_en & ~r_empty;
    assign w_rbin_next = r_rbin + PW'(w_rd_fire);

    binary_to_gray #(.WIDTH(PW)) u_rgray (
        .i_bin  (w_rbin_next),
        .o_gray (w_rgray_next)
    );

    gray_to_binary #(.WIDTH(PW)) u_wbin (
        .i_gray (rq2_wptr),
        .o_bin  (w_wbin_s)
    );

    // Modular difference stays correct across pointer wrap. Using rbin_next
    // and the current synchronised write pointer lets a same-cycle pop and
    // write advance cancel out.
    assign w_level_next = w_wbin_s - w_rbin_next;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_rbin         <= '0;
            r_rgray        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_level        <= '0;
        end else begin
            r_rbin         <= w_rbin_next;
            r_rgray        <= w_rgray_next;
            r_empty        <= (w_rgray_next == rq2_wptr);
            r_almost_empty <= (w_level_next <= PW'(AE_THRESH));
            r_level        <= w_level_next;
        end
    end

`ifdef RD_UNDERFLOW_EN
    logic r_underflow;

    // A rejected pop takes priority over a clear in the same cycle.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_underflow <= 1'b0;
        end else if (rd_en && r_empty) begin
            r_underflow <= 1'b1;
        end else if (uf_clr) begin
            r_underflow <= 1'b0;
        end
    end

    assign underflow = r_underflow;
`else
    logic w_unused_uf_clr;
    assign w_unused_uf_clr = uf_clr;
    assign underflow       = 1'b0;
`endif

    assign rd_fire      = w_rd_fire;
    assign rd_ptr       = r_rbin[ADDR_SIZE-1:0];
    assign rd_ptr_gray  = r_rgray;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign rd_level     = r_level;

endmodule

// File: doc/rd_ptr_level.md
# rd_ptr_level

Read-side pointer and status controller for the asynchronous FIFO, running entirely in the read clock domain. It keeps the binary and Gray read pointers and the registered empty flag. It also reconstructs the synchronised write pointer into binary so that it can report a read-side fill level, an almost-empty flag with a parametrised threshold, and an optional sticky underflow flag. It sits between the read port of the dual-port FIFO memory and the write-to-read two-flop pointer synchroniser.

## Interface
- ADDR_SIZE, 4: memory address width. FIFO depth = 2^ADDR_SIZE. Pointers are ADDR_SIZE+1 bits.
- AE_THRESH, 2: almost-empty threshold in entries. Legal range 0 .. 2^ADDR_SIZE-1.

Ports:
- rd_clk  in  1  read-domain clock.
- rd_rst  in  1  reset, asynchronous, active-high.
- rd_en  in  1  pop request.
- rq2_wptr  in  ADDR_SIZE+1  Gray write pointer, already two-flop synchronised into rd_clk.
- uf_clr  in  1  clears the sticky underflow flag.
- rd_fire  out  1  accepted pop, combinational: rd_en & ~empty. This is the memory read enable.
- rd_ptr  out  ADDR_SIZE  memory read address, equal to rbin[ADDR_SIZE-1:0].
- rd_ptr_gray  out  ADDR_SIZE+1  registered Gray read pointer, sent to the write domain.
- empty  out  1  registered empty flag.
- almost_empty  out  1  registered; asserted when the level is at or below AE_THRESH.
- rd_level  out  ADDR_SIZE+1  registered count of unread entries, range 0 .. 2^ADDR_SIZE.
- underflow  out  1  sticky flag, set on a pop attempt while empty.

## Operation
- rbin is an ADDR_SIZE+1 bit binary read pointer.
- rbin_next = rbin + rd_fire. It wraps modulo 2^(ADDR_SIZE+1).
- rgray_next = bin2gray(rbin_next).
- On each rd_clk edge: rbin <= rbin_next, rd_ptr_gray <= rgray_next.
- empty <= (rgray_next == rq2_wptr).
- wbin_s = gray2bin(rq2_wptr), combinational.
- level_next = (wbin_s - rbin_next) mod 2^(ADDR_SIZE+1).
- On each edge: rd_level <= level_next, almost_empty <= (level_next <= AE_THRESH).
- Invariant: rd_level == 0 exactly when empty == 1. A level of 2^ADDR_SIZE means full as seen from the read side.
- Pop while empty (rd_en=1, empty=1):
  - The pointer does not move and rd_fire=0.
  - With the macro compiled in, underflow is set.
- underflow:
  - Set by a rejected pop.
  - Cleared by uf_clr.
  - If both happen in the same cycle, set wins.
- rd_level is conservative. It lags the true fill by the synchroniser delay and never overstates the number of entries.
- Reset values:
  - rbin = 0, rd_ptr = 0, rd_ptr_gray = 0.
  - empty = 1, almost_empty = 1, rd_level = 0, underflow = 0.
- Reset is honoured mid-operation: all state returns to the reset values immediately and asynchronously.

## Timing
- All outputs are registered except rd_fire, which is combinational from rd_en and empty.
- A pop presented in cycle N:
  - rd_ptr advances at edge N+1.
  - empty, almost_empty and rd_level reflect that pop at edge N+1, with no extra latency.
- A change on rq2_wptr in cycle N is reflected in empty, rd_level and almost_empty at edge N+1.
- Total write-to-empty-deassert latency is therefore the 2 synchroniser cycles plus this 1 cycle.
- A pop and a write-pointer advance in the same cycle net out: level_next uses both the new rbin_next and the new wbin_s.
- Wrap-around: when rbin goes from 2^(ADDR_SIZE+1)-1 to 0, only one Gray bit changes and the level stays correct through modular subtraction.

## Configuration
- RD_UNDERFLOW_EN
  - Defined: the sticky underflow register and the uf_clr logic are compiled in.
  - Undefined: underflow is tied to 0 and uf_clr is ignored. All other behaviour is identical.

## Structure
- A shared package fifo_pkg holds:
  - functions bin2gray and gray2bin, parametrised by width;
  - the pointer width, expressed as ADDR_SIZE+1.
- One sub-module, gray_to_binary, parameter WIDTH, performs the wbin_s conversion. It mirrors the existing binary_to_gray, which is reused for rgray_next.

## Test plan
Parameters: ADDR_SIZE=4, AE_THRESH=2.
- Reset: assert rd_rst mid-stream -> rd_ptr=0, rd_ptr_gray=0, empty=1, almost_empty=1, rd_level=0, underflow=0, with no clock needed.
- Fill: rq2_wptr=gray(5)=5'b00111, rd_en=0 -> one edge later empty=0, rd_level=5, almost_empty=0.
- Drain: from level 5, rd_en=1 for 3 cycles -> rd_level goes 4, 3, 2; almost_empty rises with level 2; rd_ptr=3.
- Underflow: drain to empty, then hold rd_en 2 more cycles -> rd_fire=0, rd_ptr frozen at 5, underflow=1 and held. Then a uf_clr pulse -> underflow=0. Also assert uf_clr together with a rejected pop -> underflow stays 1.
- Wrap: step the pointers until rbin=30 and wbin=2 (post-wrap), i.e. rq2_wptr=gray(2) -> rd_level=4. Pop 4 -> rbin=2, empty=1; rd_ptr_gray MSB toggled at rbin=16.
- Full and simultaneous events:
  - rbin=0, rq2_wptr=gray(16) -> rd_level=16, almost_empty=0.
  - A pop plus wptr advancing to gray(17) in the same cycle -> rd_level stays 16.
